// File: rtl/acc_border.sv
`default_nettype none
// ============================================================================
// Module   : acc_border
// Purpose  : Border-PE output decoder. Counts the '1's of the unary product
//            bitstream over one temporal window, signed by the product sign,
//            adds the count to an incoming partial sum (saturating), and
//            presents the result on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module acc_border #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 clr,
    input  logic [WIDTH-2:0]     i_len,
    input  logic                 i_sign,
    input  logic [ACC_WIDTH-1:0] i_psum,
    input  logic                 i_bit,
    output logic [ACC_WIDTH-1:0] o_psum,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    // Two's-complement extremes of the accumulator and unit steps
    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-2:0]     c_REM_ONE = {{(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [WIDTH-2:0]     c_REM_ZERO = '0;

    logic [1:0]           r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [WIDTH-2:0]     r_rem;
    logic                 r_sign;
    logic [ACC_WIDTH-1:0] r_psum;
    logic                 r_valid;
    logic                 r_busy;

    logic [ACC_WIDTH-1:0] w_acc_step;
    logic [WIDTH-2:0]     w_rem_dec;

    // Next accumulator value for a RUN cycle: signed +/-1 per '1' bit, clamped at the rails
    always_comb begin
        w_acc_step = r_acc;
        if (i_bit) begin
            if (!r_sign) begin
                if (r_acc != c_ACC_MAX) begin
                    w_acc_step = r_acc + c_ACC_ONE;
                end
            end else begin
                if (r_acc != c_ACC_MIN) begin
                    w_acc_step = r_acc - c_ACC_ONE;
                end
            end
        end
    end

    // Remaining window length; held at zero rather than wrapping
    always_comb begin
        w_rem_dec = r_rem;
        if (r_rem != c_REM_ZERO) begin
            w_rem_dec = r_rem - c_REM_ONE;
        end
    end

    // Control FSM with registered outputs; clr beats init beats per-state behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_sign  <= 1'b0;
            r_psum  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else if (clr) begin
            r_state <= c_ST_IDLE;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else if (init) begin
            // A pending HOLD result is dropped here; a coincident o_ready still completes it
            r_acc  <= i_psum;
            r_rem  <= i_len;
            r_sign <= i_sign;
            if (i_len != c_REM_ZERO) begin
                r_state <= c_ST_RUN;
                r_valid <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                // Empty window: result is the incoming partial sum, available next cycle
                r_state <= c_ST_HOLD;
                r_psum  <= i_psum;
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    r_acc <= w_acc_step;
                    r_rem <= w_rem_dec;
                    if (w_rem_dec == c_REM_ZERO) begin
                        r_state <= c_ST_HOLD;
                        r_psum  <= w_acc_step;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                c_ST_HOLD: begin
                    if (o_ready) begin
                        r_state <= c_ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_psum  = r_psum;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: doc/acc_border.md
# acc_border

Binary decoder at the output end of the unary-temporal border PE. It consumes the single-bit product stream from the border multiplier over one temporal window and counts the '1's, signed by the product sign. The count is added to an incoming partial sum, and the binary result is presented on a valid/ready handshake toward the partial-sum chain.

## Interface
- WIDTH, 16, operand width of the multiplier; the window length is at most 2^(WIDTH-1)-1 cycles.
- ACC_WIDTH, 2*WIDTH, width of the two's-complement accumulator and of the partial sums.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- init  input  1  window start; same cycle as the multiplier's init.
- clr  input  1  synchronous abort; returns the block to IDLE.
- i_len  input  WIDTH-1  window length in cycles; the same value as the multiplier's temporal input magnitude; sampled on init.
- i_sign  input  1  product sign (1 = negative); sampled on init.
- i_psum  input  ACC_WIDTH  signed partial sum in; sampled on init.
- i_bit  input  1  product bitstream from the multiplier.
- o_psum  output  ACC_WIDTH  signed result; stable while o_valid=1.
- o_valid  output  1  result available.
- o_ready  input  1  downstream accepts the result.
- o_busy  output  1  window in progress (state RUN).

## Operation
- State machine: IDLE, RUN, HOLD. Reset puts the block in IDLE with o_psum=0, o_valid=0 and o_busy=0, and with acc, rem and sign all 0.
- Priority when control inputs coincide, highest first:
  - clr: go to IDLE, acc=0, o_valid=0, regardless of init or o_ready.
  - init: load acc=i_psum, rem=i_len, sign=i_sign. Next state is RUN if i_len≠0, else HOLD. Any pending HOLD result is discarded without a handshake.
  - Otherwise, normal per-state behaviour below.
- IDLE: outputs hold their values; o_valid=0.
- RUN, each cycle:
  - If i_bit=1, acc += +1 when sign=0, or −1 when sign=1.
  - rem -= 1.
  - When rem reaches 0 after the decrement, next state is HOLD.
  - i_bit is ignored in IDLE and HOLD.
- Arithmetic:
  - acc saturates at 2^(ACC_WIDTH-1)-1 and −2^(ACC_WIDTH-1); it never wraps.
  - rem is WIDTH-1 bits and never underflows.
- HOLD:
  - o_valid=1 and o_psum=acc.
  - When o_valid & o_ready, the transfer occurs; next state is IDLE and o_valid drops.
  - If o_ready=0, the block stays in HOLD indefinitely with o_psum frozen.
- o_psum is registered. It is updated on entry to HOLD and retains its value in IDLE.

## Timing
- Window alignment with the multiplier:
  - init is sampled at edge 0.
  - The bits sampled in RUN are those present at edges 1..i_len, exactly the cycles in which the multiplier's temporal bit is high.
- Latency:
  - o_valid rises in the cycle after edge i_len (i_len ≥ 1).
  - With i_len=0, o_valid rises in the cycle after edge 0 and carries o_psum=i_psum.
- Back-to-back operation:
  - Same-cycle handshake and new window: init asserted in the handshake cycle has priority; the transfer still counts if o_ready=1, and the new window starts.
  - init during RUN restarts the window; the partial count is lost.
  - Throughput is one result per i_len+1 cycles when o_ready is held at 1.
- Async reset mid-window or mid-HOLD clears everything immediately; o_valid drops without a handshake.
- o_busy=1 exactly in RUN.

## Test plan
- Positive window:
  - Stimulus: init with i_len=5, i_sign=0, i_psum=100; i_bit=1,0,1,1,0 at edges 1..5; o_ready=1.
  - Response: o_valid=1 for one cycle after edge 5 with o_psum=103, then IDLE.
- Negative sign with backpressure:
  - Stimulus: i_len=4, i_sign=1, i_psum=10, i_bit all 1; o_ready=0 for 3 cycles, then 1.
  - Response: o_psum=6 held stable with o_valid=1 for 4 cycles, then o_valid drops.
- Zero length:
  - Stimulus: i_len=0, i_psum=−7.
  - Response: o_valid in the cycle after init, o_psum=−7; i_bit toggling has no effect.
- Saturation:
  - Stimulus: ACC_WIDTH=32, i_psum=2^31−3, i_sign=0, i_len=8, i_bit all 1.
  - Response: o_psum=2^31−1.
  - Mirror case: i_psum=−2^31+2, i_sign=1, i_len=8, i_bit all 1; response o_psum=−2^31.
- Abort and restart:
  - init with i_len=10, then init again at edge 4 with i_len=2, i_psum=0, i_bit=1; response o_psum=2 after edge 6.
  - clr at edge 3 of a window; response IDLE with o_valid=0 and no result.
- Reset and pipelined windows:
  - rst_n pulsed low during HOLD; response: all outputs 0 asynchronously.
  - Back-to-back windows with init coinciding with the handshake; response: both results delivered, none lost.
  - End-to-end check against the border multiplier with random operands: o_psum − i_psum equals the multiplier's bitstream popcount, signed by i_sign.
